// File: rtl/md5_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md5_pkg
//  Description : Shared types and constants for the MD5 message padder:
//                FSM state encoding, block geometry constants and the
//                byte-to-bit mapping of a 512-bit block.
//  Revision    : 1.0 - initial release
// ============================================================================
package md5_pkg;

    localparam int          MD5_BLOCK_BYTES = 64;
    localparam int          MD5_LEN_OFFSET  = 56;
    localparam logic [7:0]  MD5_PAD_BYTE    = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_FILL       = 3'd2,
        ST_PAD        = 3'd3,
        ST_ISSUE_WAIT = 3'd4,
        ST_ISSUE      = 3'd5,
        ST_WAIT_DONE  = 3'd6
    } md5_state_t;

    // Block word i occupies [511-32i -: 32]; this returns its LSB position.
    function automatic int md5_word_lsb(input int word_idx);
        return 480 - 32 * word_idx;
    endfunction

    // Byte 0 of each word sits in the word's low byte.
    function automatic int md5_byte_lsb(input int byte_idx);
        return md5_word_lsb(byte_idx / 4) + 8 * (byte_idx % 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md5_msg_padder_if.sv
`default_nettype none
// ============================================================================
//  Module      : md5_msg_padder_if
//  Description : Word stream carrying the unpadded message into the padder.
//                master = message producer, slave = padder.
//                in_valid/in_ready handshake, in_data (byte 0 in [7:0]),
//                in_last marks the final word, in_nbytes its valid bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface md5_msg_padder_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_nbytes;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output in_nbytes,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  in_nbytes,
        output in_ready
    );

endinterface
`default_nettype wire

// File: rtl/md5_block_builder.sv
`default_nettype none
// ============================================================================
//  Module      : md5_block_builder
//  Description : Byte-addressed 64-byte block register.
//                wr_*  : write a word's valid bytes at a word-aligned
//                        pointer; the first write of a block (pointer 0)
//                        also clears every other byte.
//                pad_* : optional 0x80 at pad_ptr, zero from pad_ptr up.
//                len_* : with pad_en, place the 64-bit length in 56..63.
//                block : current block, word i at [511-32i -: 32].
//  Revision    : 1.0 - initial release
// ============================================================================
module md5_block_builder
    import md5_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         wr_en,
    input  wire logic [6:0]   wr_ptr,
    input  wire logic [31:0]  wr_data,
    input  wire logic [2:0]   wr_nbytes,
    input  wire logic         pad_en,
    input  wire logic [6:0]   pad_ptr,
    input  wire logic         pad_mark,
    input  wire logic         len_en,
    input  wire logic [63:0]  len_val,
    output logic      [511:0] block
);

    logic [511:0] r_block;

    // Clearing lazily on the first write keeps the previous block stable
    // for the cycle following its strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_block <= '0;
        end else if (wr_en) begin
            for (int j = 0; j < MD5_BLOCK_BYTES; j++) begin
                if ((7'(j) >> 2) == (wr_ptr >> 2)) begin
                    if (3'(j % 4) < wr_nbytes)
                        r_block[md5_byte_lsb(j) +: 8] <= wr_data[8*(j%4) +: 8];
                    else
                        r_block[md5_byte_lsb(j) +: 8] <= 8'h00;
                end else if (wr_ptr == 7'd0) begin
                    r_block[md5_byte_lsb(j) +: 8] <= 8'h00;
                end
            end
        end else if (pad_en) begin
            for (int j = 0; j < MD5_BLOCK_BYTES; j++) begin
                if (7'(j) == pad_ptr && pad_mark)
                    r_block[md5_byte_lsb(j) +: 8] <= MD5_PAD_BYTE;
                else if (7'(j) >= pad_ptr)
                    r_block[md5_byte_lsb(j) +: 8] <= 8'h00;
            end
            // Later assignments win, so the length overrides the zero tail.
            if (len_en) begin
                for (int k = 0; k < 8; k++)
                    r_block[md5_byte_lsb(MD5_LEN_OFFSET + k) +: 8] <= len_val[8*k +: 8];
            end
        end
    end

    assign block = r_block;

endmodule
`default_nettype wire

// File: rtl/md5_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module      : md5_msg_padder
//  Description : Assembles an unpadded 32-bit word stream into MD5 blocks,
//                appends 0x80 / zero fill / 64-bit LE bit length and feeds
//                the core under its ready handshake.
//  Ports       : clk, rst (sync, active high); in_if (slave word stream);
//                core_init, core_msg_padded, core_msg_in_valid to the core;
//                core_ready, core_msg_out_valid from the core;
//                busy (message in progress), msg_done (final digest seen).
//  Revision    : 1.0 - initial release
// ============================================================================
module md5_msg_padder
    import md5_pkg::*;
#(
    parameter int LEN_W    = 64,
    parameter int INIT_GAP = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    md5_msg_padder_if.slave    in_if,
    output logic               core_init,
    output logic [511:0]       core_msg_padded,
    output logic               core_msg_in_valid,
    input  wire logic          core_ready,
    input  wire logic          core_msg_out_valid,
    output logic               busy,
    output logic               msg_done
);

    md5_state_t       r_state, w_state_nxt;
    logic [1:0]       r_gap_cnt, w_gap_nxt;
    logic [6:0]       r_ptr, w_ptr_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    logic             r_final, w_final_nxt;
    logic             r_pending, w_pending_nxt;   // length-only block still owed
    logic             r_pad_done, w_pad_done_nxt; // 0x80 already placed
    logic             r_msg_done, w_msg_done_nxt;

    logic             w_in_ready, w_accept;
    logic [2:0]       w_nbytes;
    logic [5:0]       w_bits;
    logic [6:0]       w_ptr_sum;
    logic             w_wr_en, w_pad_en, w_pad_mark, w_len_en;
    logic [63:0]      w_len64;

    assign w_in_ready = (r_state == ST_FILL) && (r_ptr < 7'(MD5_BLOCK_BYTES));
    assign w_accept   = in_if.in_valid && w_in_ready;
    assign w_nbytes   = !in_if.in_last ? 3'd4 :
                        (in_if.in_nbytes > 3'd4) ? 3'd4 : in_if.in_nbytes;
    assign w_bits     = {w_nbytes, 3'b000};
    assign w_ptr_sum  = r_ptr + {4'b0000, w_nbytes};

    generate
        if (LEN_W == 64) begin : g_len_full
            assign w_len64 = r_len;
        end else begin : g_len_zext
            assign w_len64 = {{(64-LEN_W){1'b0}}, r_len};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gap_cnt  <= '0;
            r_ptr      <= '0;
            r_len      <= '0;
            r_final    <= 1'b0;
            r_pending  <= 1'b0;
            r_pad_done <= 1'b0;
            r_msg_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_ptr      <= w_ptr_nxt;
            r_len      <= w_len_nxt;
            r_final    <= w_final_nxt;
            r_pending  <= w_pending_nxt;
            r_pad_done <= w_pad_done_nxt;
            r_msg_done <= w_msg_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gap_nxt      = r_gap_cnt;
        w_ptr_nxt      = r_ptr;
        w_len_nxt      = r_len;
        w_final_nxt    = r_final;
        w_pending_nxt  = r_pending;
        w_pad_done_nxt = r_pad_done;
        w_msg_done_nxt = 1'b0;
        w_wr_en        = 1'b0;
        w_pad_en       = 1'b0;
        w_pad_mark     = 1'b0;
        w_len_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_if.in_valid) begin
                    w_state_nxt    = ST_START;
                    w_gap_nxt      = '0;
                    w_ptr_nxt      = '0;
                    w_len_nxt      = '0;
                    w_final_nxt    = 1'b0;
                    w_pending_nxt  = 1'b0;
                    w_pad_done_nxt = 1'b0;
                end
            end
            ST_START: begin
                // First START cycle carries core_init, then INIT_GAP quiet cycles.
                if (r_gap_cnt == 2'(INIT_GAP))
                    w_state_nxt = ST_FILL;
                else
                    w_gap_nxt = r_gap_cnt + 2'd1;
            end
            ST_FILL: begin
                if (w_accept) begin
                    w_wr_en   = 1'b1;
                    w_ptr_nxt = w_ptr_sum;
                    w_len_nxt = r_len + LEN_W'(w_bits);
                    if (in_if.in_last) begin
                        w_state_nxt = ST_PAD;
                    end else if (w_ptr_sum == 7'(MD5_BLOCK_BYTES)) begin
                        w_final_nxt = 1'b0;
                        w_state_nxt = ST_ISSUE_WAIT;
                    end
                end
            end
            ST_PAD: begin
                // Pointer 64 means no room for 0x80; it moves to the next block.
                w_pad_en       = 1'b1;
                w_pad_mark     = !r_pad_done && (r_ptr < 7'(MD5_BLOCK_BYTES));
                w_pad_done_nxt = r_pad_done | w_pad_mark;
                if (r_ptr < 7'(MD5_LEN_OFFSET)) begin
                    w_len_en      = 1'b1;
                    w_final_nxt   = 1'b1;
                    w_pending_nxt = 1'b0;
                end else begin
                    w_final_nxt   = 1'b0;
                    w_pending_nxt = 1'b1;
                end
                w_state_nxt = ST_ISSUE_WAIT;
            end
            ST_ISSUE_WAIT: begin
                if (core_ready)
                    w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (r_final) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else begin
                    w_ptr_nxt   = '0;
                    w_state_nxt = r_pending ? ST_PAD : ST_FILL;
                end
            end
            ST_WAIT_DONE: begin
                if (core_msg_out_valid) begin
                    w_msg_done_nxt = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    md5_block_builder u_builder (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (w_wr_en),
        .wr_ptr    (r_ptr),
        .wr_data   (in_if.in_data),
        .wr_nbytes (w_nbytes),
        .pad_en    (w_pad_en),
        .pad_ptr   (r_ptr),
        .pad_mark  (w_pad_mark),
        .len_en    (w_len_en),
        .len_val   (w_len64),
        .block     (core_msg_padded)
    );

    assign in_if.in_ready    = w_in_ready;
    assign core_init         = (r_state == ST_START) && (r_gap_cnt == 2'd0);
    assign core_msg_in_valid = (r_state == ST_ISSUE);
    assign busy              = (r_state != ST_IDLE);
    assign msg_done          = r_msg_done;

endmodule
`default_nettype wire

// File: tb/tb_md5_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md5_msg_padder
//  Description : Directed self-checking bench for md5_msg_padder. Expected
//                blocks come from an in-bench MD5 padding model plus
//                hand-computed pad/length words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md5_msg_padder;

    logic         clk;
    logic         rst;
    logic         core_init;
    logic [511:0] core_msg_padded;
    logic         core_msg_in_valid;
    logic         core_ready;
    logic         core_msg_out_valid;
    logic         busy;
    logic         msg_done;

    md5_msg_padder_if in_if ();

    md5_msg_padder #(
        .LEN_W    (64),
        .INIT_GAP (1)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .in_if              (in_if),
        .core_init          (core_init),
        .core_msg_padded    (core_msg_padded),
        .core_msg_in_valid  (core_msg_in_valid),
        .core_ready         (core_ready),
        .core_msg_out_valid (core_msg_out_valid),
        .busy               (busy),
        .msg_done           (msg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fails  = 0;
    logic [511:0]  blocks[$];
    int            n_init   = 0;
    int            n_done   = 0;
    logic [7:0]    msg [64];

    always @(negedge clk) begin
        if (core_msg_in_valid) blocks.push_back(core_msg_padded);
        if (core_init)         n_init++;
        if (msg_done)          n_done++;
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [511:0] b, input int i);
        return b[511-32*i -: 32];
    endfunction

    // Reference MD5 padding of msg[0..len-1]; returns block number blk.
    function automatic logic [511:0] exp_block(input int len, input int blk);
        logic [7:0]   p [128];
        logic [63:0]  bits;
        logic [511:0] r;
        int           nb;
        for (int i = 0; i < 128; i++) p[i] = 8'h00;
        for (int i = 0; i < len; i++) p[i] = msg[i];
        p[len] = 8'h80;
        nb   = (len <= 55) ? 1 : 2;
        bits = 64'(len) * 64'd8;
        for (int k = 0; k < 8; k++) p[64*nb-8+k] = bits[8*k +: 8];
        r = '0;
        for (int b = 0; b < 64; b++) r[480 - 32*(b/4) + 8*(b%4) +: 8] = p[64*blk + b];
        return r;
    endfunction

    task automatic fill_msg(input int seed);
        for (int i = 0; i < 64; i++) msg[i] = 8'(i * 13 + seed + 1);
    endtask

    task automatic set_abc();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    endtask

    // Streams msg[0..len-1]; unused byte lanes carry 0xEE. abort_at >= 0
    // presents that word and then pulses rst instead of finishing.
    task automatic send_msg(input int len, input int nb_ovr, input int abort_at);
        int   nw;
        int   nb;
        int   cyc;
        logic acc;
        nw = (len == 0) ? 1 : (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < 4; k++)
                in_if.in_data[8*k +: 8] = (4*w + k < len) ? msg[4*w + k] : 8'hEE;
            in_if.in_last = (w == nw - 1);
            nb = (w == nw - 1) ? (len - 4*w) : 4;
            if (w == nw - 1 && nb_ovr >= 0) nb = nb_ovr;
            in_if.in_nbytes = 3'(nb);
            in_if.in_valid  = 1'b1;
            if (w == abort_at) begin
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                in_if.in_valid = 1'b0;
                in_if.in_last  = 1'b0;
                return;
            end
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 100) begin
                @(negedge clk);
                acc = in_if.in_ready;
                @(posedge clk);
                #1;
                cyc++;
            end
            check_eq("word_accept", acc, 1'b1);
        end
        in_if.in_valid = 1'b0;
        in_if.in_last  = 1'b0;
    endtask

    // Called between edges while the padder awaits the digest.
    task automatic finish_msg();
        core_msg_out_valid = 1'b1;
        @(posedge clk);
        #1;
        core_msg_out_valid = 1'b0;
        @(negedge clk);
        check_eq("msg_done_pulse", msg_done, 1'b1);
        check_eq("busy_after_done", busy, 1'b0);
        @(negedge clk);
        check_eq("msg_done_one_cycle", msg_done, 1'b0);
    endtask

    task automatic run_case(input string name, input int len, input int nb_ovr, input int exp_n);
        int cyc;
        blocks.delete();
        n_init = 0;
        n_done = 0;
        send_msg(len, nb_ovr, -1);
        cyc = 0;
        while (blocks.size() < exp_n && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        finish_msg();
        check_eq({name, "_nblocks"}, blocks.size(), exp_n);
        for (int b = 0; b < exp_n; b++)
            check_eq({name, "_block"}, blocks[b], exp_block((nb_ovr > 4) ? 4 : len, b));
        check_eq({name, "_init_pulses"}, n_init, 1);
        check_eq({name, "_done_pulses"}, n_done, 1);
    endtask

    logic [511:0] snap;
    logic         ok;

    initial begin
        rst                = 1'b1;
        core_ready         = 1'b1;
        core_msg_out_valid = 1'b0;
        in_if.in_valid     = 1'b0;
        in_if.in_data      = '0;
        in_if.in_last      = 1'b0;
        in_if.in_nbytes    = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", in_if.in_ready, 1'b0);
        check_eq("rst_core_init", core_init, 1'b0);
        check_eq("rst_strobe", core_msg_in_valid, 1'b0);
        check_eq("rst_msg_done", msg_done, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_block", core_msg_padded, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // "abc"
        fill_msg(0);
        set_abc();
        run_case("abc", 3, -1, 1);
        check_eq("abc_w0", wd(blocks[0], 0), 32'h80636261);
        check_eq("abc_w14", wd(blocks[0], 14), 32'h00000018);
        check_eq("abc_w15", wd(blocks[0], 15), 32'h00000000);

        // 55 bytes: 0x80 lands at byte 55, single block
        fill_msg(5);
        run_case("m55", 55, -1, 1);
        check_eq("m55_pad", wd(blocks[0], 13) & 32'hFF000000, 32'h80000000);
        check_eq("m55_w14", wd(blocks[0], 14), 32'h000001B8);

        // 56 bytes: 0x80 at byte 56, length in a second block
        fill_msg(9);
        run_case("m56", 56, -1, 2);
        check_eq("m56_b1_w14", wd(blocks[0], 14), 32'h00000080);
        check_eq("m56_b1_w15", wd(blocks[0], 15), 32'h00000000);
        check_eq("m56_b2", blocks[1], {448'd0, 32'h000001C0, 32'd0});

        // 64 bytes: no room for 0x80 in block 1
        fill_msg(17);
        run_case("m64", 64, -1, 2);
        check_eq("m64_b2_w0", wd(blocks[1], 0), 32'h00000080);
        check_eq("m64_b2_w14", wd(blocks[1], 14), 32'h00000200);

        // empty message
        run_case("empty", 0, -1, 1);
        check_eq("empty_block", blocks[0], {32'h00000080, 480'd0});

        // in_nbytes = 7 on the last word is treated as 4
        fill_msg(33);
        run_case("clamp", 4, 7, 1);
        check_eq("clamp_w1", wd(blocks[0], 1), 32'h00000080);
        check_eq("clamp_w14", wd(blocks[0], 14), 32'h00000020);

        // core_ready low for 20+ cycles in ISSUE_WAIT; stray digest ignored
        fill_msg(0);
        set_abc();
        blocks.delete();
        n_done = 0;
        core_ready = 1'b0;
        send_msg(3, -1, -1);
        @(posedge clk);
        @(negedge clk);
        snap = core_msg_padded;
        ok = 1'b1;
        core_msg_out_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (core_msg_in_valid || in_if.in_ready || msg_done || core_msg_padded !== snap)
                ok = 1'b0;
        end
        core_msg_out_valid = 1'b0;
        check_eq("hold_quiet_stable", ok, 1'b1);
        check_eq("hold_block", snap, exp_block(3, 0));
        @(posedge clk);
        #1;
        core_ready = 1'b1;
        @(negedge clk);
        check_eq("hold_strobe_early", core_msg_in_valid, 1'b0);
        @(negedge clk);
        check_eq("hold_strobe", core_msg_in_valid, 1'b1);
        check_eq("hold_strobe_block", core_msg_padded, snap);
        @(negedge clk);
        check_eq("hold_strobe_width", core_msg_in_valid, 1'b0);
        check_eq("hold_post_issue_block", core_msg_padded, snap);
        finish_msg();
        check_eq("hold_nblocks", blocks.size(), 1);
        check_eq("hold_done_pulses", n_done, 1);

        // reset during FILL of word 7, then a fresh "abc"
        fill_msg(41);
        blocks.delete();
        send_msg(40, -1, 7);
        @(negedge clk);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_in_ready", in_if.in_ready, 1'b0);
        check_eq("midrst_block", core_msg_padded, '0);
        repeat (5) @(negedge clk);
        check_eq("midrst_no_strobe", blocks.size(), 0);
        @(posedge clk);
        #1;
        fill_msg(0);
        set_abc();
        run_case("abc_after_rst", 3, -1, 1);
        check_eq("abc_after_rst_w0", wd(blocks[0], 0), 32'h80636261);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
